aes_inv_key_stream: RTL and testbench

AES_INV_KEY_STREAM -- requirements
Module: aes_inv_key_stream

---
 rtl/aes_inv_key_stream_pkg.sv | 67 ++++++
 rtl/aes_inv_key_step.sv | 20 ++
 rtl/key_schedule.sv | 20 ++
 rtl/aes_inv_key_stream.sv | 95 +++++++++
 tb/tb_aes_inv_key_stream.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/aes_inv_key_stream_pkg.sv
// Shared AES definitions: stream FSM states, rcon table and
// byte/word helpers used by the forward and inverse key steps.
package aes_inv_key_stream_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        STREAM
    } state_t;

    function automatic logic [7:0] rcon(input logic [3:0] i);
        logic [7:0] r;
        unique case (i)
            4'd1:    r = 8'h01;
            4'd2:    r = 8'h02;
            4'd3:    r = 8'h04;
            4'd4:    r = 8'h08;
            4'd5:    r = 8'h10;
            4'd6:    r = 8'h20;
            4'd7:    r = 8'h40;
            4'd8:    r = 8'h80;
            4'd9:    r = 8'h1b;
            4'd10:   r = 8'h36;
            default: r = 8'h00;
        endcase
        return r;
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a,
                                        input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    // a^254 is the field inverse, and maps 0 to 0 as the S-box needs
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] p;
        logic [7:0] r;
        p = a;
        r = 8'h01;
        for (int i = 1; i < 8; i++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]}
                 ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subrot(input logic [31:0] w);
        return {sbox(w[23:16]), sbox(w[15:8]),
                sbox(w[7:0]), sbox(w[31:24])};
    endfunction

endpackage

// File: rtl/aes_inv_key_step.sv
// One inverse AES-128 key-schedule step: round key i to round key i-1.
module aes_inv_key_step
    import aes_inv_key_stream_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rc,
    output logic [127:0] prev_key
);

    logic [31:0] w0, w1, w2, w3;

    always_comb begin
        w3 = key[31:0] ^ key[63:32];
        w2 = key[63:32] ^ key[95:64];
        w1 = key[95:64] ^ key[127:96];
        w0 = key[127:96] ^ subrot(w3) ^ {rc, 24'h0};
        prev_key = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/key_schedule.sv
// One forward AES-128 key-schedule step: round key r-1 to round key r.
module key_schedule
    import aes_inv_key_stream_pkg::*;
(
    input  logic [127:0] key,
    input  logic [7:0]   rc,
    output logic [127:0] next_key
);

    logic [31:0] w0, w1, w2, w3;

    always_comb begin
        w0 = key[127:96] ^ subrot(key[31:0]) ^ {rc, 24'h0};
        w1 = key[95:64] ^ w0;
        w2 = key[63:32] ^ w1;
        w3 = key[31:0] ^ w2;
        next_key = {w0, w1, w2, w3};
    end

endmodule

// File: rtl/aes_inv_key_stream.sv
// Expands a cipher key forward to round 10, then streams the round
// keys 10..0 by undoing the schedule one step per handshake.
module aes_inv_key_stream
    import aes_inv_key_stream_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic [127:0] key_in,
    input  logic         key_valid,
    output logic         key_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic         rk_last
);

    state_t       state, state_nx;
    logic [3:0]   cnt;
    logic [127:0] wkey;
    logic [127:0] fwd_key;
    logic [127:0] inv_key;
    logic [7:0]   rc;
    logic         hs;

    assign rc = rcon(cnt);
    assign hs = rk_valid && rk_ready;

    key_schedule u_ks (
        .key      (wkey),
        .rc       (rc),
        .next_key (fwd_key)
    );

    aes_inv_key_step u_inv (
        .key      (wkey),
        .rc       (rc),
        .prev_key (inv_key)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (key_valid) state_nx = EXPAND;
            EXPAND:  if (cnt == 4'd10) state_nx = STREAM;
            STREAM:  if (hs && cnt == 4'd0) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        key_ready = (state == IDLE);
        rk_valid  = (state == STREAM);
        rk_last   = rk_valid && (cnt == 4'd0);
        rk_out    = wkey;
        rk_idx    = cnt;
    end

    // cnt is the forward round in EXPAND and the output round in STREAM
    always_ff @(posedge clk) begin
        if (rst) begin
            wkey <= '0;
            cnt  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (key_valid) begin
                        wkey <= key_in;
                        cnt  <= 4'd1;
                    end
                end
                EXPAND: begin
                    wkey <= fwd_key;
                    if (cnt != 4'd10) cnt <= cnt + 4'd1;
                end
                STREAM: begin
                    if (hs && cnt != 4'd0) begin
                        wkey <= inv_key;
                        cnt  <= cnt - 4'd1;
                    end
                end
                default: begin
                    wkey <= '0;
                    cnt  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_aes_inv_key_stream.sv
// Self-checking bench: software AES-128 key expansion as reference,
// random handshakes, stalls, key_valid noise, reset abort, back to back.
module tb_aes_inv_key_stream;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] key_in;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_valid;
    logic         rk_ready;
    logic         rk_last;

    int checks = 0;
    int errors = 0;

    logic [7:0]   sb[256];
    logic [127:0] got_rk[11];
    logic [3:0]   got_idx[11];
    logic         got_last[11];
    int           got_n;
    int           stall_err;
    bit           timed_out;
    logic         ready_at_last;

    aes_inv_key_stream dut (
        .clk       (clk),
        .rst       (rst),
        .key_in    (key_in),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_last   (rk_last)
    );

    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] rl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box built by walking generator 3 and its inverse together
    task automatic build_sbox();
        logic [7:0] p, q, x;
        p = 8'h01;
        q = 8'h01;
        do begin
            p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
            q = q ^ (q << 1);
            q = q ^ (q << 2);
            q = q ^ (q << 4);
            if (q[7]) q = q ^ 8'h09;
            x = q ^ rl(q, 1) ^ rl(q, 2) ^ rl(q, 3) ^ rl(q, 4);
            sb[p] = x ^ 8'h63;
        end while (p != 8'h01);
        sb[0] = 8'h63;
    endtask

    function automatic logic [127:0] ref_rk(input logic [127:0] k,
                                            input int r);
        logic [31:0] w[44];
        logic [31:0] t;
        logic [7:0]  rc;
        w[0] = k[127:96];
        w[1] = k[95:64];
        w[2] = k[63:32];
        w[3] = k[31:0];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sb[t[23:16]], sb[t[15:8]], sb[t[7:0]], sb[t[31:24]]}
                    ^ {rc, 24'h0};
                rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endfunction

    task automatic start_key(input logic [127:0] k);
        key_in = k;
        key_valid = 1'b1;
        rk_ready = 1'b0;
        @(posedge clk); #1;
        key_valid = 1'b0;
    endtask

    // Gathers 11 handshaken keys; pulses key_valid with junk at p1/p2
    task automatic collect(input bit rnd, input logic [127:0] junk,
                           input int p1, input int p2);
        int cyc;
        bit stalled;
        logic [127:0] po;
        logic [3:0] pi;
        logic pl;
        got_n = 0;
        stall_err = 0;
        timed_out = 0;
        stalled = 0;
        cyc = 0;
        po = '0;
        pi = '0;
        pl = 1'b0;
        key_in = junk;
        while (got_n < 11 && cyc < 400) begin
            key_valid = (cyc == p1 || cyc == p2);
            rk_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rk_valid) begin
                if (stalled && (rk_out !== po || rk_idx !== pi
                                || rk_last !== pl))
                    stall_err++;
                if (rk_ready) begin
                    got_rk[got_n] = rk_out;
                    got_idx[got_n] = rk_idx;
                    got_last[got_n] = rk_last;
                    if (rk_idx == 4'd0) ready_at_last = key_ready;
                    got_n++;
                end
                stalled = !rk_ready;
                po = rk_out;
                pi = rk_idx;
                pl = rk_last;
            end
            @(posedge clk); #1;
            cyc++;
        end
        key_valid = 1'b0;
        rk_ready = 1'b0;
        if (got_n < 11) timed_out = 1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        key_valid = 1'b0;
        rk_ready = 1'b0;
        key_in = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rk_valid !== 1'b0 || rk_last !== 1'b0 || rk_idx !== 4'd0) begin
            errors++;
            $display("FAIL reset_ctl: valid=%b last=%b idx=%0d expected 0 0 0",
                     rk_valid, rk_last, rk_idx);
        end
        checks++;
        if (rk_out !== 128'h0) begin
            errors++;
            $display("FAIL reset_out: got %h expected 0", rk_out);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (key_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b expected 1", key_ready);
        end
    endtask

    task automatic test_fips();
        logic [127:0] k;
        int n;
        k = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        key_in = k;
        key_valid = 1'b1;
        rk_ready = 1'b1;
        n = 0;
        while (!rk_valid && n < 40) begin
            @(posedge clk); #1;
            key_valid = 1'b0;
            n++;
        end
        checks++;
        if (n != 11) begin
            errors++;
            $display("FAIL fips_latency: got %0d cycles expected 11", n);
        end
        collect(0, k, -1, -1);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL fips_timeout: got %0d keys expected 11", got_n);
        end else begin
            checks++;
            if (got_idx[0] !== 4'd10
                || got_rk[0] !== 128'hd014f9a8c9ee2589e13f0cc8b6630ca6) begin
                errors++;
                $display("FAIL fips_rk10: got %0d %h expected 10 d014f9a8c9ee2589e13f0cc8b6630ca6",
                         got_idx[0], got_rk[0]);
            end
            checks++;
            if (got_idx[1] !== 4'd9
                || got_rk[1] !== 128'hac7766f319fadc2128d12941575c006e) begin
                errors++;
                $display("FAIL fips_rk9: got %0d %h expected 9 ac7766f319fadc2128d12941575c006e",
                         got_idx[1], got_rk[1]);
            end
            checks++;
            if (got_idx[10] !== 4'd0 || got_rk[10] !== k
                || got_last[10] !== 1'b1) begin
                errors++;
                $display("FAIL fips_rk0: got %0d %h last=%b expected 0 %h 1",
                         got_idx[10], got_rk[10], got_last[10], k);
            end
        end
        checks++;
        if (rk_valid !== 1'b0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL fips_done: valid=%b ready=%b expected 0 1",
                     rk_valid, key_ready);
        end
    endtask

    task automatic test_random_stall();
        logic [127:0] k;
        for (int t = 0; t < 4; t++) begin
            k = t == 0 ? 128'h2b7e151628aed2a6abf7158809cf4f3c
                       : {$urandom, $urandom, $urandom, $urandom};
            start_key(k);
            collect(1, k, -1, -1);
            checks++;
            if (timed_out || stall_err != 0) begin
                errors++;
                $display("FAIL stall_run%0d: keys=%0d stall_errs=%0d expected 11 0",
                         t, got_n, stall_err);
            end
            for (int j = 0; j < got_n; j++) begin
                checks++;
                if (got_idx[j] !== 4'(10 - j)
                    || got_rk[j] !== ref_rk(k, 10 - j)
                    || got_last[j] !== (j == 10)) begin
                    errors++;
                    $display("FAIL stall_rk%0d: got %0d %h last=%b expected %0d %h %b",
                             j, got_idx[j], got_rk[j], got_last[j],
                             10 - j, ref_rk(k, 10 - j), j == 10);
                end
            end
        end
    endtask

    task automatic test_ignore_key();
        logic [127:0] k;
        k = {$urandom, $urandom, $urandom, $urandom};
        start_key(k);
        collect(1, ~k, 4, 13);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL ignore_timeout: got %0d keys expected 11", got_n);
        end
        for (int j = 0; j < got_n; j++) begin
            checks++;
            if (got_idx[j] !== 4'(10 - j)
                || got_rk[j] !== ref_rk(k, 10 - j)) begin
                errors++;
                $display("FAIL ignore_rk%0d: got %0d %h expected %0d %h",
                         j, got_idx[j], got_rk[j], 10 - j, ref_rk(k, 10 - j));
            end
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL ignore_idle: valid=%b expected 0", rk_valid);
        end
    endtask

    task automatic test_reset_abort();
        logic [127:0] k;
        int n;
        k = {$urandom, $urandom, $urandom, $urandom};
        start_key(k);
        n = 0;
        while (!(rk_valid && rk_idx == 4'd5) && n < 100) begin
            rk_ready = 1'b1;
            @(posedge clk); #1;
            n++;
        end
        rk_ready = 1'b0;
        checks++;
        if (n >= 100) begin
            errors++;
            $display("FAIL abort_reach5: got idx %0d expected 5", rk_idx);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (rk_idx !== 4'd5 || rk_out !== ref_rk(k, 5)) begin
            errors++;
            $display("FAIL abort_hold: got %0d %h expected 5 %h",
                     rk_idx, rk_out, ref_rk(k, 5));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (rk_valid !== 1'b0 || rk_out !== 128'h0 || key_ready !== 1'b1) begin
            errors++;
            $display("FAIL abort_clear: valid=%b out=%h ready=%b expected 0 0 1",
                     rk_valid, rk_out, key_ready);
        end
        rk_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_quiet: valid=%b expected 0", rk_valid);
        end
        k = {$urandom, $urandom, $urandom, $urandom};
        start_key(k);
        collect(1, k, -1, -1);
        checks++;
        if (timed_out || stall_err != 0) begin
            errors++;
            $display("FAIL abort_rerun: keys=%0d stall_errs=%0d expected 11 0",
                     got_n, stall_err);
        end
        for (int j = 0; j < got_n; j++) begin
            checks++;
            if (got_idx[j] !== 4'(10 - j)
                || got_rk[j] !== ref_rk(k, 10 - j)) begin
                errors++;
                $display("FAIL abort_rk%0d: got %0d %h expected %0d %h",
                         j, got_idx[j], got_rk[j], 10 - j, ref_rk(k, 10 - j));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [127:0] k;
        ready_at_last = 1'bx;
        start_key(128'h0);
        collect(0, 128'h0, -1, -1);
        checks++;
        if (got_rk[0] !== 128'hb4ef5bcb3e92e21123e951cf6f8f188e) begin
            errors++;
            $display("FAIL b2b_zero_rk10: got %h expected b4ef5bcb3e92e21123e951cf6f8f188e",
                     got_rk[0]);
        end
        checks++;
        if (ready_at_last !== 1'b0 || key_ready !== 1'b1
            || rk_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap: ready_at_hs=%b ready=%b valid=%b expected 0 1 0",
                     ready_at_last, key_ready, rk_valid);
        end
        k = {128{1'b1}};
        start_key(k);
        collect(0, k, -1, -1);
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL b2b_timeout: got %0d keys expected 11", got_n);
        end
        for (int j = 0; j < got_n; j++) begin
            checks++;
            if (got_idx[j] !== 4'(10 - j)
                || got_rk[j] !== ref_rk(k, 10 - j)
                || got_last[j] !== (j == 10)) begin
                errors++;
                $display("FAIL b2b_ones_rk%0d: got %0d %h expected %0d %h",
                         j, got_idx[j], got_rk[j], 10 - j, ref_rk(k, 10 - j));
            end
        end
    endtask

    initial begin
        build_sbox();
        test_reset();
        test_fips();
        test_random_stall();
        test_ignore_key();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
